// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite line fetcher
package sprite_pkg;

  localparam int SPRITE_PIXELS = 32;
  localparam int PIXEL_W       = 8;
  localparam int LINE_W        = 256;
  localparam int VRAM_ADDR_W   = 12;

  typedef logic [PIXEL_W-1:0] pixel_t;
  typedef logic [LINE_W-1:0]  sprite_line_t;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, STREAM} fetch_state_t;

  // Pixel 0 lives in the most significant byte of the line.
  function automatic pixel_t line_pixel(input sprite_line_t line, input logic [4:0] idx);
    return line[(LINE_W-1) - PIXEL_W*int'(idx) -: PIXEL_W];
  endfunction

endpackage

// File: rtl/sprite_pixel_serializer.sv
// rtl/sprite_pixel_serializer.sv - line buffer and valid/ready pixel streamer
module sprite_pixel_serializer
  import sprite_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         capture_i,
  input  sprite_line_t line_i,
  input  logic         hflip_i,
  input  logic         pix_ready_i,
  output logic         pix_valid_o,
  output pixel_t       pix_data_o,
  output logic [4:0]   pix_index_o,
  output logic         pix_transparent_o,
  output logic         pix_last_o,
  output logic         done_o
);

  sprite_line_t line_q, line_d;
  logic [4:0]   col_q, col_d;
  logic         valid_q, valid_d;
  logic         flip_q, flip_d;
  logic         handshake;
  logic         last;

  assign last      = (col_q == 5'(SPRITE_PIXELS-1));
  assign handshake = valid_q && pix_ready_i;
  assign done_o    = handshake && last;

  always_comb begin
    line_d  = line_q;
    col_d   = col_q;
    valid_d = valid_q;
    flip_d  = flip_q;
    if (flush_i) begin
      valid_d = 1'b0;
      col_d   = 5'd0;
    end else if (capture_i) begin
      line_d  = line_i;
      col_d   = 5'd0;
      valid_d = 1'b1;
      flip_d  = hflip_i;
    end else if (handshake) begin
      if (last) begin
        valid_d = 1'b0;
        col_d   = 5'd0;
      end else begin
        col_d = col_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      line_q  <= '0;
      col_q   <= 5'd0;
      valid_q <= 1'b0;
      flip_q  <= 1'b0;
    end else begin
      line_q  <= line_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      flip_q  <= flip_d;
    end
  end

  // 31-c for a 5-bit column is its bitwise complement.
  assign pix_data_o        = line_pixel(line_q, flip_q ? ~col_q : col_q);
  assign pix_index_o       = col_q;
  assign pix_valid_o       = valid_q;
  assign pix_last_o        = last;
  assign pix_transparent_o = (pix_data_o == '0);

endmodule

// File: rtl/sprite_line_fetcher.sv
// rtl/sprite_line_fetcher.sv - request FSM and VRAM addressing for one sprite line
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int SPRITE_ID_W  = 7,
  parameter int ROW_W        = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [SPRITE_ID_W-1:0] req_sprite_id_i,
  input  logic [ROW_W-1:0]       req_row_i,
  input  logic                   req_hflip_i,
  input  logic                   flush_i,
  output logic [VRAM_ADDR_W-1:0] vram_read_addr_o,
  input  logic [LINE_W-1:0]      vram_read_data_i,
  output logic                   pix_valid_o,
  input  logic                   pix_ready_i,
  output logic [PIXEL_W-1:0]     pix_data_o,
  output logic [4:0]             pix_index_o,
  output logic                   pix_transparent_o,
  output logic                   pix_last_o,
  output logic                   busy_o
);

  fetch_state_t           state_q;
  logic [VRAM_ADDR_W-1:0] addr_q;
  logic                   hflip_q;
  logic                   busy_q;
  logic                   req_ready_q;
  logic [1:0]             lat_q;
  logic                   capture;
  logic                   line_done;

  assign capture = (state_q == WAIT) && (lat_q == 2'd0) && !flush_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      hflip_q     <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
      lat_q       <= 2'd0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          addr_q      <= {req_sprite_id_i, req_row_i};
          hflip_q     <= req_hflip_i;
          busy_q      <= 1'b1;
          req_ready_q <= 1'b0;
          state_q     <= ADDR;
        end
        ADDR: begin
          lat_q   <= 2'(READ_LATENCY - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_q == 2'd0) state_q <= STREAM;
          else lat_q <= lat_q - 2'd1;
        end
        STREAM: if (line_done) begin
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush in IDLE must block the same-cycle request.
  assign req_ready_o      = req_ready_q && !flush_i;
  assign busy_o           = busy_q;
  assign vram_read_addr_o = addr_q;

  sprite_pixel_serializer u_serializer (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .flush_i           (flush_i),
    .capture_i         (capture),
    .line_i            (vram_read_data_i),
    .hflip_i           (hflip_q),
    .pix_ready_i       (pix_ready_i),
    .pix_valid_o       (pix_valid_o),
    .pix_data_o        (pix_data_o),
    .pix_index_o       (pix_index_o),
    .pix_transparent_o (pix_transparent_o),
    .pix_last_o        (pix_last_o),
    .done_o            (line_done)
  );

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb/tb_sprite_line_fetcher.sv - directed self-checking bench for sprite_line_fetcher
module tb_sprite_line_fetcher;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0, req_valid2 = 1'b0;
  logic [6:0]   req_sprite_id = '0;
  logic [4:0]   req_row = '0;
  logic         req_hflip = 1'b0;
  logic         flush = 1'b0, flush2 = 1'b0;
  logic         pix_ready = 1'b1, pix_ready2 = 1'b1;
  logic         req_ready, req_ready2;
  logic [11:0]  vram_addr, vram_addr2;
  logic [255:0] vram_rd1, vram_rd2a, vram_rd2;
  logic         pix_valid, pix_valid2;
  logic [7:0]   pix_data, pix_data2;
  logic [4:0]   pix_index, pix_index2;
  logic         pix_transp, pix_transp2;
  logic         pix_last, pix_last2;
  logic         busy, busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sprite_line_fetcher #(.READ_LATENCY(1)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sprite_id_i(req_sprite_id), .req_row_i(req_row), .req_hflip_i(req_hflip),
    .flush_i(flush), .vram_read_addr_o(vram_addr), .vram_read_data_i(vram_rd1),
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready), .pix_data_o(pix_data),
    .pix_index_o(pix_index), .pix_transparent_o(pix_transp), .pix_last_o(pix_last),
    .busy_o(busy));

  sprite_line_fetcher #(.READ_LATENCY(2)) dut2 (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
    .req_sprite_id_i(req_sprite_id), .req_row_i(req_row), .req_hflip_i(req_hflip),
    .flush_i(flush2), .vram_read_addr_o(vram_addr2), .vram_read_data_i(vram_rd2),
    .pix_valid_o(pix_valid2), .pix_ready_i(pix_ready2), .pix_data_o(pix_data2),
    .pix_index_o(pix_index2), .pix_transparent_o(pix_transp2), .pix_last_o(pix_last2),
    .busy_o(busy2));

  function automatic logic [7:0] exp_pix(input logic [11:0] a, input int p);
    if (a == 12'h006 && p == 7) return 8'h00;
    if (a == 12'h005 || a == 12'h006) return 8'(p + 1);
    return a[7:0] ^ 8'(p);
  endfunction

  function automatic logic [255:0] vram_line(input logic [11:0] a);
    logic [255:0] l;
    l = '0;
    for (int p = 0; p < 32; p++) l[255-8*p -: 8] = exp_pix(a, p);
    return l;
  endfunction

  always @(posedge clk) begin
    vram_rd1  <= vram_line(vram_addr);
    vram_rd2a <= vram_line(vram_addr2);
    vram_rd2  <= vram_rd2a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_req(input logic [6:0] id, input logic [4:0] row, input logic hf,
                        input logic [11:0] eaddr, input bit hold);
    @(posedge clk); #1;
    req_sprite_id = id; req_row = row; req_hflip = hf; req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 1);
    @(posedge clk); #1;
    if (hold) begin
      req_sprite_id = 7'h12; req_row = 5'h03;
    end else begin
      req_valid = 1'b0;
    end
    @(negedge clk);
    check("addr_t1", 32'(vram_addr), 32'(eaddr));
    check("busy_t1", 32'(busy), 1);
    check("req_ready_t1", 32'(req_ready), 0);
    check("pix_valid_t1", 32'(pix_valid), 0);
    @(negedge clk);
    check("pix_valid_t2", 32'(pix_valid), 0);
  endtask

  task automatic stream_check(input logic [11:0] a, input logic hf, input logic bp,
                              output logic [7:0] first, output logic [7:0] final_px,
                              output int tcount, output int tidx);
    int cnt = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [12:0] prev = '0;
    logic [7:0] e;
    tcount = 0; tidx = -1; first = '0; final_px = '0;
    while (cnt < 32 && cyc < 200) begin
      @(posedge clk); #1;
      pix_ready = bp ? (cyc % 3 == 0) : 1'b1;
      @(negedge clk);
      if (cyc == 0) check("first_valid", 32'(pix_valid), 1);
      if (pix_valid) begin
        e = exp_pix(a, hf ? 31 - cnt : cnt);
        if (stalled) check("stall_stable", 32'({pix_index, pix_data}), 32'(prev));
        check("pix_index", 32'(pix_index), 32'(cnt));
        check("pix_data", 32'(pix_data), 32'(e));
        check("pix_last", 32'(pix_last), 32'(cnt == 31));
        check("pix_transp", 32'(pix_transp), 32'(e == 8'h00));
        check("req_ready_stream", 32'(req_ready), 0);
        check("addr_stream", 32'(vram_addr), 32'(a));
        prev = {pix_index, pix_data};
        stalled = !pix_ready;
        if (pix_ready) begin
          if (cnt == 0) first = pix_data;
          if (cnt == 31) final_px = pix_data;
          if (pix_transp) begin tcount++; tidx = cnt; end
          cnt++;
        end
      end
      cyc++;
    end
    check("handshakes", 32'(cnt), 32);
    @(posedge clk); #1;
    pix_ready = 1'b1;
    @(negedge clk);
    check("end_valid", 32'(pix_valid), 0);
    check("end_busy", 32'(busy), 0);
    check("end_req_ready", 32'(req_ready), 1);
  endtask

  typedef struct {
    logic [6:0]  id;
    logic [4:0]  row;
    logic        hflip;
    logic        bp;
    logic [11:0] exp_addr;
    logic [7:0]  exp_first;
    logic [7:0]  exp_final;
    int          exp_tidx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] f, l;
    int tc, ti, seen;

    vecs[0] = '{7'h00, 5'h05, 1'b0, 1'b0, 12'h005, 8'h01, 8'h20, -1};
    vecs[1] = '{7'h00, 5'h05, 1'b1, 1'b0, 12'h005, 8'h20, 8'h01, -1};
    vecs[2] = '{7'h00, 5'h06, 1'b0, 1'b0, 12'h006, 8'h01, 8'h20, 7};
    vecs[3] = '{7'h00, 5'h05, 1'b0, 1'b1, 12'h005, 8'h01, 8'h20, -1};
    vecs[4] = '{7'h7F, 5'h1F, 1'b0, 1'b0, 12'hFFF, 8'hFF, 8'hE0, -1};
    vecs[5] = '{7'h7F, 5'h1F, 1'b1, 1'b1, 12'hFFF, 8'hE0, 8'hFF, -1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", 32'(vram_addr), 0);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_data", 32'(pix_data), 0);
    check("rst_index", 32'(pix_index), 0);
    check("rst_last", 32'(pix_last), 0);
    check("rst_transp", 32'(pix_transp), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_req(vecs[i].id, vecs[i].row, vecs[i].hflip, vecs[i].exp_addr, 1'b0);
      stream_check(vecs[i].exp_addr, vecs[i].hflip, vecs[i].bp, f, l, tc, ti);
      check("vec_first", 32'(f), 32'(vecs[i].exp_first));
      check("vec_final", 32'(l), 32'(vecs[i].exp_final));
      check("vec_tcount", 32'(tc), 32'(vecs[i].exp_tidx >= 0 ? 1 : 0));
      check("vec_tidx", 32'(ti), 32'(vecs[i].exp_tidx));
    end

    // Request held high through STREAM is taken the cycle after the last handshake.
    do_req(7'h00, 5'h05, 1'b0, 12'h005, 1'b1);
    stream_check(12'h005, 1'b0, 1'b0, f, l, tc, ti);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("held_addr", 32'(vram_addr), 32'h243);
    check("held_busy", 32'(busy), 1);
    @(negedge clk);
    stream_check(12'h243, 1'b0, 1'b0, f, l, tc, ti);

    // Flush while pixel 10 is presented.
    do_req(7'h00, 5'h05, 1'b0, 12'h005, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    check("flush_at_idx", 32'(pix_index), 10);
    check("flush_at_valid", 32'(pix_valid), 1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(pix_valid), 0);
    check("flush_busy", 32'(busy), 0);
    check("flush_last", 32'(pix_last), 0);
    check("flush_addr", 32'(vram_addr), 32'h005);

    // Flush together with a request in IDLE.
    @(posedge clk); #1;
    req_sprite_id = 7'h7F; req_row = 5'h1F; flush = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    check("flushreq_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flushreq_busy", 32'(busy), 0);
    check("flushreq_addr", 32'(vram_addr), 32'h005);

    // READ_LATENCY=2 instance.
    @(posedge clk); #1;
    req_sprite_id = 7'h00; req_row = 5'h06; req_hflip = 1'b0; req_valid2 = 1'b1;
    @(negedge clk);
    check("rl2_req_ready", 32'(req_ready2), 1);
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    @(negedge clk);
    check("rl2_addr", 32'(vram_addr2), 32'h006);
    check("rl2_valid_t1", 32'(pix_valid2), 0);
    @(negedge clk);
    check("rl2_valid_t2", 32'(pix_valid2), 0);
    @(negedge clk);
    check("rl2_valid_t3", 32'(pix_valid2), 0);
    @(negedge clk);
    for (int c = 0; c < 32; c++) begin
      check("rl2_valid", 32'(pix_valid2), 1);
      check("rl2_data", 32'(pix_data2), 32'(exp_pix(12'h006, c)));
      check("rl2_index", 32'(pix_index2), 32'(c));
      check("rl2_last", 32'(pix_last2), 32'(c == 31));
      @(negedge clk);
    end
    check("rl2_end_valid", 32'(pix_valid2), 0);
    check("rl2_end_busy", 32'(busy2), 0);

    // Asynchronous reset while waiting on VRAM.
    do_req(7'h00, 5'h05, 1'b0, 12'h005, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_addr", 32'(vram_addr), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_req_ready", 32'(req_ready), 1);
    check("arst_valid", 32'(pix_valid), 0);
    check("arst_data", 32'(pix_data), 0);
    check("arst_transp", 32'(pix_transp), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pix_valid) seen++;
    end
    check("arst_no_valid", 32'(seen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
